// File: rtl/com_pkg.sv
// Shared definitions for the command receive path and the command parser:
// FSM state encodings, payload layout constants and small helpers.
package com_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_RECV  = 5'b00010,
      ST_CHECK = 5'b00100,
      ST_SEND  = 5'b01000,
      ST_DROP  = 5'b10000
   } rx_state_t;

   localparam logic [15:0] STD_HEAD        = 16'h55AA;
   localparam int          HEAD_OFS        = 0;
   localparam int          SUM_OFS         = 16;
   localparam logic [7:0]  PAYLOAD_OFS_DEF = 8'h0A;
   localparam logic [7:0]  PAYLOAD_LEN_DEF = 8'h12;

   // Counters that report discards stick at all-ones rather than wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/com_rx_sum.sv
// Payload checksum/head tracker for com_rx_store: assembles big-endian words
// from the byte stream by RAM address and keeps a wrapping 16-bit sum.
module com_rx_sum
   import com_pkg::*;
#(
   parameter int         ADDR_W      = 8,
   parameter logic [7:0] PAYLOAD_OFS = PAYLOAD_OFS_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            byte_en,
   input  logic [ADDR_W:0] addr,
   input  logic [7:0]      data,
   output logic            sum_ok
);
   localparam int OFS_I = int'(PAYLOAD_OFS);

   int          rel;
   logic [7:0]  hi;
   logic [15:0] word;
   logic [15:0] acc;
   logic [15:0] head;
   logic [15:0] stored;

   assign rel  = int'(addr) - OFS_I;
   assign word = {hi, data};

   // Even payload offsets hold the high byte; the odd byte completes the word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi     <= 8'h00;
         acc    <= 16'h0000;
         head   <= 16'h0000;
         stored <= 16'h0000;
      end else if (start) begin
         acc    <= 16'h0000;
         head   <= 16'h0000;
         stored <= 16'h0000;
      end else if (byte_en && rel >= 0 && rel < SUM_OFS + 2) begin
         if (!rel[0])
            hi <= data;
         else if (rel == HEAD_OFS + 1)
            head <= word;
         else if (rel == SUM_OFS + 1)
            stored <= word;
         else
            acc <= acc + word;
      end
   end

   assign sum_ok = (head == STD_HEAD) && (acc == stored);

endmodule

// File: rtl/com_rx_store.sv
// Receive-side frame store: writes each incoming frame into command RAM from
// address 0 and hands it to the parser via fs/fd. Build macro COM_RX_SUM_CHECK_EN adds head/checksum validation.
module com_rx_store
   import com_pkg::*;
#(
   parameter int         ADDR_W      = 8,
   parameter logic [7:0] PAYLOAD_OFS = PAYLOAD_OFS_DEF,
   parameter logic [7:0] PAYLOAD_LEN = PAYLOAD_LEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_last,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_wa,
   output logic [7:0]        ram_wd,
   output logic              fs,
   input  logic              fd,
   output logic [ADDR_W:0]   frame_len,
   output logic [7:0]        drop_cnt
);
   localparam int              MIN_LEN_I = int'(PAYLOAD_OFS) + int'(PAYLOAD_LEN);
   localparam logic [ADDR_W:0] MIN_LEN   = MIN_LEN_I[ADDR_W:0];
   localparam logic [ADDR_W:0] FULL      = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

   rx_state_t       state;
   logic [ADDR_W:0] cnt;
   logic            in_frame;
   logic            frame_start;
   logic            check_ok;

   assign frame_start = rx_valid && !in_frame;

`ifdef COM_RX_SUM_CHECK_EN
   com_rx_sum #(
      .ADDR_W      (ADDR_W),
      .PAYLOAD_OFS (PAYLOAD_OFS)
   ) u_sum (
      .clk     (clk),
      .rst     (rst),
      .start   (state == ST_IDLE && frame_start),
      .byte_en (state == ST_RECV && rx_valid && cnt != FULL),
      .addr    (cnt),
      .data    (rx_data),
      .sum_ok  (check_ok)
   );
`else
   assign check_ok = 1'b1;
`endif

   // in_frame follows every byte regardless of state, so a frame tail arriving
   // after a handoff is never mistaken for a new frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         ram_we    <= 1'b0;
         ram_wa    <= '0;
         ram_wd    <= 8'h00;
         fs        <= 1'b0;
         frame_len <= '0;
         drop_cnt  <= 8'h00;
         cnt       <= '0;
         in_frame  <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         fs     <= (state == ST_SEND) && !fd;
         if (rx_valid)
            in_frame <= !rx_last;

         unique case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  ram_we <= 1'b1;
                  ram_wa <= '0;
                  ram_wd <= rx_data;
                  cnt    <= ONE;
                  state  <= rx_last ? ST_CHECK : ST_RECV;
               end
            end
            ST_RECV: begin
               if (rx_valid) begin
                  if (cnt == FULL) begin
                     drop_cnt <= sat_inc(drop_cnt);
                     state    <= rx_last ? ST_IDLE : ST_DROP;
                  end else begin
                     ram_we <= 1'b1;
                     ram_wa <= cnt[ADDR_W-1:0];
                     ram_wd <= rx_data;
                     cnt    <= cnt + ONE;
                     if (rx_last)
                        state <= ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               if (cnt < MIN_LEN || !check_ok) begin
                  drop_cnt <= sat_inc(drop_cnt);
                  state    <= ST_IDLE;
               end else begin
                  frame_len <= cnt;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (frame_start)
                  drop_cnt <= sat_inc(drop_cnt);
               if (fd)
                  state <= ST_IDLE;
            end
            ST_DROP: begin
               if (rx_valid && rx_last)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
